// File: rtl/des_key_schedule_stream.sv
// DES round-key generator: PC-1 on Start, then streams 16 PC-2 subkeys over valid/ready.
// Define DES_KEY_PARITY_CHECK_EN to build the odd-parity check on the key bytes.
module des_key_schedule_stream #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Start,
  input  logic        Decrypt,
  input  logic [63:0] Key,
  output logic        Busy,
  output logic        RoundKeyValid,
  input  logic        RoundKeyReady,
  output logic [47:0] RoundKey,
  output logic [3:0]  RoundIndex,
  output logic        Done,
  output logic        ParityError
);

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [1:0] SHIFTS [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                         2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  // DES bit n (1-based, MSB first) lives at vector index WIDTH-n.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  function automatic logic [55:0] rot1(input logic [55:0] cd, input logic right);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (right) return {c[0], c[27:1], d[0], d[27:1]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_next;
  logic [3:0]  cnt_q;
  logic        dec_q;
  logic [1:0]  shift_amt;
  logic        last_hs;

  // Rotation is applied when the next key is built; the stalled key never rotates.
  always_comb begin
    shift_amt = SHIFTS[cnt_q];
    if (dec_q) shift_amt = (cnt_q == 4'd0) ? 2'd0 : SHIFTS[4'd0 - cnt_q];
    cd_next = cd_q;
    if (shift_amt != 2'd0) cd_next = rot1(cd_q, dec_q);
    if (shift_amt == 2'd2) cd_next = rot1(rot1(cd_q, dec_q), dec_q);
  end

  assign last_hs = RoundKeyValid && RoundKeyReady && (cnt_q == 4'(NUM_ROUNDS - 1));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_EMIT;
      S_EMIT:  if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cd_q          <= '0;
      cnt_q         <= '0;
      dec_q         <= 1'b0;
      RoundKey      <= '0;
      RoundIndex    <= '0;
      RoundKeyValid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Start) begin
          cd_q  <= pc1(Key);
          dec_q <= Decrypt;
          cnt_q <= '0;
        end
        S_EMIT: if (!RoundKeyValid) begin
          cd_q          <= cd_next;
          RoundKey      <= pc2(cd_next);
          RoundIndex    <= dec_q ? 4'd15 - cnt_q : cnt_q;
          RoundKeyValid <= 1'b1;
        end else if (RoundKeyReady) begin
          RoundKeyValid <= 1'b0;
          cnt_q         <= cnt_q + 4'd1;
        end
        default: RoundKeyValid <= 1'b0;
      endcase
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_DONE);

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_bad;
  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) if (~^Key[8*b +: 8]) par_bad = 1'b1;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)                       ParityError <= 1'b0;
    else if (state_q == S_IDLE && Start) ParityError <= par_bad;
  end
`else
  assign ParityError = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule_stream.sv
// Directed bench for des_key_schedule_stream with a cumulative-shift DES key model.
`timescale 1ns/1ps
module tb_des_key_schedule_stream;
  logic        Clk = 1'b0, nReset = 1'b0, Start = 1'b0, Decrypt = 1'b0, RoundKeyReady = 1'b0;
  logic [63:0] Key = '0;
  logic        Busy, RoundKeyValid, Done, ParityError;
  logic [47:0] RoundKey;
  logic [3:0]  RoundIndex;

  des_key_schedule_stream dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Decrypt(Decrypt), .Key(Key),
    .Busy(Busy), .RoundKeyValid(RoundKeyValid), .RoundKeyReady(RoundKeyReady),
    .RoundKey(RoundKey), .RoundIndex(RoundIndex), .Done(Done), .ParityError(ParityError)
  );

  always #5 Clk = ~Clk;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h123457799BBCDFF1;

  int PC1 [1:56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                     10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                     14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int PC2 [1:48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                     23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SH [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int          checks = 0, errors = 0;
  logic [47:0] mkeys [16];
  logic        mdec = 1'b0, mpar = 1'b0, chk_en = 1'b0;
  logic        prev_done = 1'b0, prev_stall = 1'b0;
  int          ptr = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // K_r = PC2 of (C0,D0) each rotated left by the total shift of rounds 1..r.
  function automatic void build_model(input logic [63:0] key);
    bit k [1:64];
    bit c0 [1:28];
    bit d0 [1:28];
    bit cd [1:56];
    int s;
    for (int i = 1; i <= 64; i++) k[i] = key[64-i];
    for (int i = 1; i <= 28; i++) begin
      c0[i] = k[PC1[i]];
      d0[i] = k[PC1[i+28]];
    end
    s = 0;
    for (int r = 1; r <= 16; r++) begin
      s += SH[r];
      for (int i = 1; i <= 28; i++) begin
        cd[i]    = c0[((i - 1 + s) % 28) + 1];
        cd[i+28] = d0[((i - 1 + s) % 28) + 1];
      end
      for (int j = 1; j <= 48; j++) mkeys[r-1][48-j] = cd[PC2[j]];
    end
    mpar = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) mpar = 1'b1;
  endfunction

  function automatic logic exp_parity();
`ifdef DES_KEY_PARITY_CHECK_EN
    return mpar;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge Clk) begin : cmp
    int ei;
    if (chk_en && nReset) begin
      ei = mdec ? 15 - ptr : ptr;
      if (RoundKeyValid) begin
        if (ptr > 15) chk("extra_key", 64'(ptr), 64'd15);
        else begin
          chk("round_key", 64'(RoundKey), 64'(mkeys[ei]));
          chk("round_index", 64'(RoundIndex), 64'(ei));
        end
        if (RoundKeyReady) ptr++;
      end
      if (prev_stall) chk("valid_hold", 64'(RoundKeyValid), 64'd1);
      prev_stall = RoundKeyValid && !RoundKeyReady;
      if (Busy) chk("parity_error", 64'(ParityError), 64'(exp_parity()));
      if (Done) chk("done_pulse_width", 64'(prev_done), 64'd0);
      prev_done = Done;
    end
  end

  task automatic run(input logic [63:0] key, input logic dec, input bit stall,
                     input bit glitch, input bit done_start, input bit abort);
    int sc;
    int cyc;
    sc = 0;
    build_model(key);
    mdec = dec;
    ptr = 0;
    prev_done = 1'b0;
    prev_stall = 1'b0;
    @(posedge Clk); #1;
    Key = key; Decrypt = dec; Start = 1'b1; RoundKeyReady = 1'b0; chk_en = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Key = ~key; Decrypt = ~dec; RoundKeyReady = 1'b1;
    chk("busy_on_accept", 64'(Busy), 64'd1);
    chk("valid_before_first", 64'(RoundKeyValid), 64'd0);
    @(posedge Clk); #1;
    chk("valid_first_latency", 64'(RoundKeyValid), 64'd1);
    if (key == KEY_A) chk("first_key_literal", 64'(RoundKey), dec ? 64'h0000CB3D8B0E17F5 : 64'h00001B02EFFC7072);
    cyc = 0;
    while (!Done && cyc < 200) begin
      if (abort && ptr == 7) begin
        nReset = 1'b0; #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_valid", 64'(RoundKeyValid), 64'd0);
        chk("abort_key", 64'(RoundKey), 64'd0);
        chk("abort_index", 64'(RoundIndex), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_parity", 64'(ParityError), 64'd0);
        chk_en = 1'b0;
        repeat (3) begin
          @(posedge Clk); #1;
          chk("abort_no_done", 64'(Done), 64'd0);
        end
        nReset = 1'b1;
        repeat (3) begin
          @(posedge Clk); #1;
          chk("abort_idle_no_done", 64'(Done | Busy), 64'd0);
        end
        return;
      end
      if (stall && ptr == 2 && RoundKeyValid && sc < 5) begin
        RoundKeyReady = 1'b0;
        if (sc > 0) chk("stall_index", 64'(RoundIndex), 64'd2);
        sc++;
      end else RoundKeyReady = 1'b1;
      if (glitch && ptr == 5) begin
        Start = 1'b1; Key = 64'h0123456789ABCDEF; Decrypt = 1'b1;
      end else Start = 1'b0;
      @(posedge Clk); #1;
      cyc++;
    end
    Start = 1'b0;
    chk("done_seen", 64'(Done), 64'd1);
    chk("done_after_16", 64'(ptr), 64'd16);
    chk("done_valid_low", 64'(RoundKeyValid), 64'd0);
    chk("done_busy", 64'(Busy), 64'd1);
    if (done_start) begin
      Start = 1'b1; Key = KEY_B;
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("idle_after_done", 64'(Busy), 64'd0);
    chk("done_cleared", 64'(Done), 64'd0);
    @(posedge Clk); #1;
    chk("no_start_from_done", 64'(Busy | RoundKeyValid), 64'd0);
    chk_en = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_valid", 64'(RoundKeyValid), 64'd0);
    chk("reset_key", 64'(RoundKey), 64'd0);
    chk("reset_index", 64'(RoundIndex), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_parity", 64'(ParityError), 64'd0);
    @(posedge Clk); #1;
    nReset = 1'b1;

    build_model(KEY_A);
    chk("model_k1", 64'(mkeys[0]), 64'h00001B02EFFC7072);
    chk("model_k2", 64'(mkeys[1]), 64'h000079AED9DBC9E5);
    chk("model_k15", 64'(mkeys[14]), 64'h0000BF918D3D3F0A);
    chk("model_k16", 64'(mkeys[15]), 64'h0000CB3D8B0E17F5);
    chk("model_parity_a", 64'(mpar), 64'd0);
    build_model(KEY_B);
    chk("model_parity_b", 64'(mpar), 64'd1);

    run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(KEY_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(KEY_A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(KEY_B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("parity_held_after_done", 64'(ParityError), 64'(exp_parity()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
